sram_arbiter: RTL and testbench



---
 rtl/sram_arb_pkg.sv | 19 +
 rtl/sram_arb_pick.sv | 40 ++++
 rtl/sram_arbiter.sv | 150 +++++++++++++++
 tb/tb_sram_arbiter.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared types and default widths for the SRAM arbiter
package sram_arb_pkg;

    localparam int ADDR_W_DEF = 19;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        WRITE = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'b00,
        GNT_RD   = 2'b01,
        GNT_WR   = 2'b10
    } gnt_t;

endpackage

// File: rtl/sram_arb_pick.sv
// sram_arb_pick: combinational grant policy for the SRAM arbiter
//   rd_req, wr_req : pending requests
//   rd_streak      : consecutive read grants (fixed-priority mode)
//   last_grant     : 1 = last grant was a write (round-robin mode)
//   gnt            : selected grant
//   Macro SRAM_ARB_RR_EN selects strict alternation instead of read
//   priority with a starvation guard.
module sram_arb_pick
    import sram_arb_pkg::*;
#(
    parameter int STK_W         = 4,
    parameter int MAX_RD_STREAK = 8
) (
    input  logic             rd_req,
    input  logic             wr_req,
    input  logic [STK_W-1:0] rd_streak,
    input  logic             last_grant,
    output gnt_t             gnt
);

`ifdef SRAM_ARB_RR_EN
    logic unused_streak;
    assign unused_streak = ^{rd_streak, STK_W'(MAX_RD_STREAK)};

    always_comb
        gnt = (rd_req && wr_req) ? (last_grant ? GNT_RD : GNT_WR) :
              rd_req             ? GNT_RD :
              wr_req             ? GNT_WR : GNT_NONE;
`else
    logic unused_last;
    assign unused_last = last_grant;

    // A saturated read streak hands the slot to a waiting writer.
    always_comb
        gnt = (wr_req && rd_streak == STK_W'(MAX_RD_STREAK)) ? GNT_WR :
              rd_req                                        ? GNT_RD :
              wr_req                                        ? GNT_WR : GNT_NONE;
`endif

endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one single-port SRAM controller between a display reader and a writer
//   clk, rst (sync, active-high)
//   rd_req/rd_addr -> rd_gnt, rd_valid, rd_data   : display read port
//   wr_req/wr_addr/wr_data -> wr_gnt, wr_done     : write port
//   mem_rd_req/mem_wr_req/mem_addr/mem_wdata/mem_rdata : controller side
//   busy : high while an access is in flight
//   Macro SRAM_ARB_RR_EN (in sram_arb_pick) switches to round-robin arbitration.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W        = ADDR_W_DEF,
    parameter int DATA_W        = DATA_W_DEF,
    parameter int ACC_CYCLES    = 2,
    parameter int MAX_RD_STREAK = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_gnt,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_gnt,
    output logic              wr_done,
    output logic              mem_rd_req,
    output logic              mem_wr_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int CNT_W = $clog2(ACC_CYCLES + 1);
    localparam int STK_W = $clog2(MAX_RD_STREAK + 1);

    state_t            state, state_d;
    gnt_t              gnt;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic [STK_W-1:0]  rd_streak, rd_streak_d;
    logic              last_grant, last_grant_d;
    logic              rd_gnt_d, rd_valid_d, wr_gnt_d, wr_done_d;
    logic              mem_rd_req_d, mem_wr_req_d, busy_d;
    logic [DATA_W-1:0] rd_data_d, mem_wdata_d;
    logic [ADDR_W-1:0] mem_addr_d;

    sram_arb_pick #(
        .STK_W        (STK_W),
        .MAX_RD_STREAK(MAX_RD_STREAK)
    ) u_pick (
        .rd_req    (rd_req),
        .wr_req    (wr_req),
        .rd_streak (rd_streak),
        .last_grant(last_grant),
        .gnt       (gnt)
    );

    // Outputs are computed one cycle ahead and registered, so cnt counts
    // remaining access cycles: 0 marks the last cycle of mem_*_req.
    always_comb begin
        state_d      = state;
        cnt_d        = cnt;
        rd_streak_d  = rd_streak;
        last_grant_d = last_grant;
        rd_gnt_d     = 1'b0;
        rd_valid_d   = 1'b0;
        wr_gnt_d     = 1'b0;
        wr_done_d    = 1'b0;
        rd_data_d    = rd_data;
        mem_rd_req_d = mem_rd_req;
        mem_wr_req_d = mem_wr_req;
        mem_addr_d   = mem_addr;
        mem_wdata_d  = mem_wdata;
        case (state)
            IDLE: begin
                if (!rd_req)
                    rd_streak_d = '0;
                if (gnt == GNT_RD) begin
                    state_d      = READ;
                    cnt_d        = CNT_W'(ACC_CYCLES - 1);
                    rd_gnt_d     = 1'b1;
                    mem_rd_req_d = 1'b1;
                    mem_addr_d   = rd_addr;
                    rd_streak_d  = (rd_streak == STK_W'(MAX_RD_STREAK)) ? rd_streak : rd_streak + 1'b1;
                    last_grant_d = 1'b0;
                end else if (gnt == GNT_WR) begin
                    state_d      = WRITE;
                    cnt_d        = CNT_W'(ACC_CYCLES - 1);
                    wr_gnt_d     = 1'b1;
                    mem_wr_req_d = 1'b1;
                    mem_addr_d   = wr_addr;
                    mem_wdata_d  = wr_data;
                    rd_streak_d  = '0;
                    last_grant_d = 1'b1;
                end
            end
            READ, WRITE: begin
                if (cnt == '0) begin
                    state_d      = IDLE;
                    mem_rd_req_d = 1'b0;
                    mem_wr_req_d = 1'b0;
                    rd_valid_d   = (state == READ);
                    wr_done_d    = (state == WRITE);
                    rd_data_d    = (state == READ) ? mem_rdata : rd_data;
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            rd_streak  <= '0;
            last_grant <= 1'b1;
            rd_gnt     <= 1'b0;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
            wr_gnt     <= 1'b0;
            wr_done    <= 1'b0;
            mem_rd_req <= 1'b0;
            mem_wr_req <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            busy       <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            rd_streak  <= rd_streak_d;
            last_grant <= last_grant_d;
            rd_gnt     <= rd_gnt_d;
            rd_valid   <= rd_valid_d;
            rd_data    <= rd_data_d;
            wr_gnt     <= wr_gnt_d;
            wr_done    <= wr_done_d;
            mem_rd_req <= mem_rd_req_d;
            mem_wr_req <= mem_wr_req_d;
            mem_addr   <= mem_addr_d;
            mem_wdata  <= mem_wdata_d;
            busy       <= busy_d;
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed self-checking bench for sram_arbiter
`define CHK(t, o, e) check(t, 32'(o), 32'(e))
module tb_sram_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd_req = 1'b0;
  logic [18:0] rd_addr = '0;
  logic        rd_gnt, rd_valid;
  logic [15:0] rd_data;
  logic        wr_req = 1'b0;
  logic [18:0] wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic        wr_gnt, wr_done;
  logic        mem_rd_req, mem_wr_req;
  logic [18:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic        busy;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  sram_arbiter #(
    .ADDR_W(19), .DATA_W(16), .ACC_CYCLES(2), .MAX_RD_STREAK(8)
  ) dut (
    .clk(clk), .rst(rst),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_gnt(wr_gnt), .wr_done(wr_done),
    .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    int n;
    logic exp_wr;
    rd_req = 1'b1;
    wr_req = 1'b1;
    rd_addr = 19'h00005;
    repeat (3) tick();
    `CHK("rst_rd_gnt", rd_gnt, 0);
    `CHK("rst_wr_gnt", wr_gnt, 0);
    `CHK("rst_mem_rd_req", mem_rd_req, 0);
    `CHK("rst_mem_wr_req", mem_wr_req, 0);
    `CHK("rst_busy", busy, 0);
    `CHK("rst_rd_data", rd_data, 0);
    `CHK("rst_mem_addr", mem_addr, 0);
    rst = 1'b0;
    tick();
    `CHK("first_rd_gnt", rd_gnt, 1);
    `CHK("first_wr_gnt", wr_gnt, 0);
    rd_req = 1'b0;
    wr_req = 1'b0;
    repeat (6) tick();
    `CHK("settle_busy", busy, 0);
    rd_addr = 19'h00010;
    rd_req = 1'b1;
    tick();
    `CHK("rd_gnt_t1", rd_gnt, 1);
    `CHK("rd_mem_req_t1", mem_rd_req, 1);
    `CHK("rd_mem_addr_t1", mem_addr, 19'h00010);
    `CHK("rd_busy_t1", busy, 1);
    rd_req = 1'b0;
    rd_addr = 19'h00000;
    mem_rdata = 16'h5555;
    tick();
    `CHK("rd_gnt_t2", rd_gnt, 0);
    `CHK("rd_mem_req_t2", mem_rd_req, 1);
    `CHK("rd_mem_addr_t2", mem_addr, 19'h00010);
    `CHK("rd_valid_t2", rd_valid, 0);
    mem_rdata = 16'hBEEF;
    tick();
    `CHK("rd_valid_t3", rd_valid, 1);
    `CHK("rd_data_t3", rd_data, 16'hBEEF);
    `CHK("rd_mem_req_t3", mem_rd_req, 0);
    `CHK("rd_busy_t3", busy, 0);
    mem_rdata = 16'h7777;
    tick();
    `CHK("rd_valid_t4", rd_valid, 0);
    `CHK("rd_data_hold", rd_data, 16'hBEEF);
    wr_addr = 19'h7FFFF;
    wr_data = 16'h1234;
    wr_req = 1'b1;
    tick();
    `CHK("wr_gnt_t1", wr_gnt, 1);
    `CHK("wr_mem_req_t1", mem_wr_req, 1);
    `CHK("wr_mem_rd_t1", mem_rd_req, 0);
    `CHK("wr_mem_addr_t1", mem_addr, 19'h7FFFF);
    `CHK("wr_mem_wdata_t1", mem_wdata, 16'h1234);
    wr_req = 1'b0;
    wr_addr = 19'h00000;
    wr_data = 16'h0000;
    tick();
    `CHK("wr_gnt_t2", wr_gnt, 0);
    `CHK("wr_mem_req_t2", mem_wr_req, 1);
    `CHK("wr_mem_addr_t2", mem_addr, 19'h7FFFF);
    `CHK("wr_mem_wdata_t2", mem_wdata, 16'h1234);
    `CHK("wr_done_t2", wr_done, 0);
    tick();
    `CHK("wr_done_t3", wr_done, 1);
    `CHK("wr_mem_req_t3", mem_wr_req, 0);
    `CHK("wr_mem_rd_t3", mem_rd_req, 0);
    `CHK("wr_busy_t3", busy, 0);
    tick();
    rd_addr = 19'h00AAA;
    wr_addr = 19'h00BBB;
    wr_data = 16'h00CC;
    rd_req = 1'b1;
    wr_req = 1'b1;
    tick();
    `CHK("sim_rd_gnt", rd_gnt, 1);
    `CHK("sim_wr_gnt_t1", wr_gnt, 0);
    `CHK("sim_rd_addr", mem_addr, 19'h00AAA);
    rd_req = 1'b0;
    repeat (2) tick();
    `CHK("sim_rd_valid", rd_valid, 1);
    `CHK("sim_wr_gnt_t3", wr_gnt, 0);
    tick();
    `CHK("sim_wr_gnt_t4", wr_gnt, 1);
    `CHK("sim_wr_addr", mem_addr, 19'h00BBB);
    `CHK("sim_wr_data", mem_wdata, 16'h00CC);
    wr_req = 1'b0;
    repeat (2) tick();
    `CHK("sim_wr_done", wr_done, 1);
    tick();
    rd_addr = 19'h11111;
    wr_addr = 19'h22222;
    rd_req = 1'b1;
    wr_req = 1'b1;
    n = 0;
    for (int cyc = 0; cyc < 200 && n < 27; cyc++) begin
      tick();
      checks++;
      if ((mem_rd_req & mem_wr_req) !== 1'b0) begin
        errors++;
        $error("FAIL mutex");
      end
      if (rd_gnt || wr_gnt) begin
`ifdef SRAM_ARB_RR_EN
        exp_wr = (n % 2) == 1;
`else
        exp_wr = (n % 9) == 8;
`endif
        checks++;
        if ({rd_gnt, wr_gnt} !== (exp_wr ? 2'b01 : 2'b10)) begin
          errors++;
          $error("FAIL pat_gnt%0d observed %b", n, {rd_gnt, wr_gnt});
        end
        checks++;
        if (mem_addr !== (exp_wr ? 19'h22222 : 19'h11111)) begin
          errors++;
          $error("FAIL pat_addr%0d observed %0h", n, mem_addr);
        end
        n++;
      end
    end
    `CHK("pat_count", n, 27);
    rd_req = 1'b0;
    wr_req = 1'b0;
    repeat (4) tick();
    `CHK("pat_idle", busy, 0);
    rd_addr = 19'h00321;
    mem_rdata = 16'hCAFE;
    rd_req = 1'b1;
    tick();
    `CHK("abort_gnt", rd_gnt, 1);
    rst = 1'b1;
    rd_req = 1'b0;
    tick();
    `CHK("abort_mem_req", mem_rd_req, 0);
    `CHK("abort_busy", busy, 0);
    `CHK("abort_rd_data", rd_data, 0);
    `CHK("abort_mem_addr", mem_addr, 0);
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (rd_valid) n++;
    end
    `CHK("abort_no_valid", n, 0);
    `CHK("abort_idle", busy, 0);
    `CHK("abort_rd_data_end", rd_data, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
